// File: rtl/lab1_imul_pow_initiator.sv
// Integer power engine: base^exp mod 2^p_nbits.
// Drives an external multiplier over en/rdy.
module lab1_imul_pow_initiator #(
  parameter int p_nbits = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_en,
  output logic                 req_rdy,
  input  logic [2*p_nbits-1:0] req_msg,
  output logic                 resp_en,
  input  logic                 resp_rdy,
  output logic [p_nbits-1:0]   resp_msg,
  output logic                 mul_req_en,
  input  logic                 mul_req_rdy,
  output logic [2*p_nbits-1:0] mul_req_msg,
  input  logic                 mul_resp_en,
  output logic                 mul_resp_rdy,
  input  logic [p_nbits-1:0]   mul_resp_msg
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CHECK    = 3'd1;
  localparam logic [2:0] MUL_REQ  = 3'd2;
  localparam logic [2:0] MUL_WAIT = 3'd3;
  localparam logic [2:0] SQ_REQ   = 3'd4;
  localparam logic [2:0] SQ_WAIT  = 3'd5;
  localparam logic [2:0] DONE     = 3'd6;

  localparam logic [p_nbits-1:0] ONE =
    {{(p_nbits-1){1'b0}}, 1'b1};

  logic [2:0]         state_q, state_d;
  logic [p_nbits-1:0] acc_q, acc_d;
  logic [p_nbits-1:0] b_q, b_d;
  logic [p_nbits-1:0] e_q, e_d;

  logic [p_nbits-1:0] req_base;
  logic [p_nbits-1:0] req_exp;

  assign req_base = req_msg[2*p_nbits-1:p_nbits];
  assign req_exp  = req_msg[p_nbits-1:0];
  assign resp_msg = acc_q;

  // Handshake outputs decoded from the current state.
  always_comb begin
    req_rdy      = 1'b0;
    resp_en      = 1'b0;
    mul_req_en   = 1'b0;
    mul_resp_rdy = 1'b0;
    mul_req_msg  = '0;
    unique case (state_q)
      IDLE: req_rdy = 1'b1;
      MUL_REQ: begin
        mul_req_msg = {acc_q, b_q};
        mul_req_en  = mul_req_rdy;
      end
      SQ_REQ: begin
        mul_req_msg = {b_q, b_q};
        mul_req_en  = mul_req_rdy;
      end
      MUL_WAIT,
      SQ_WAIT: mul_resp_rdy = 1'b1;
      DONE: resp_en = resp_rdy;
      default: ;
    endcase
  end

  // Square-and-multiply sequencing, LSB first.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    b_d     = b_q;
    e_d     = e_q;
    unique case (state_q)
      IDLE: begin
        if (req_en) begin
          acc_d   = ONE;
          b_d     = req_base;
          e_d     = req_exp;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (e_q == '0)
          state_d = DONE;
        else if (e_q[0])
          state_d = MUL_REQ;
        else
          state_d = SQ_REQ;
      end
      MUL_REQ: begin
        if (mul_req_en)
          state_d = MUL_WAIT;
      end
      MUL_WAIT: begin
        if (mul_resp_en) begin
          acc_d = mul_resp_msg;
          // Last set bit: skip the useless square.
          if (e_q[p_nbits-1:1] == '0) begin
            e_d     = '0;
            state_d = DONE;
          end else begin
            state_d = SQ_REQ;
          end
        end
      end
      SQ_REQ: begin
        if (mul_req_en)
          state_d = SQ_WAIT;
      end
      SQ_WAIT: begin
        if (mul_resp_en) begin
          b_d     = mul_resp_msg;
          e_d     = e_q >> 1;
          state_d = CHECK;
        end
      end
      DONE: begin
        if (resp_en)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= ONE;
      b_q     <= '0;
      e_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      e_q     <= e_d;
    end
  end

endmodule

// File: doc/lab1_imul_pow_initiator.md
Name: lab1_imul_pow_initiator

Overview:
- Integer exponentiation engine that acts as the initiator (client) of the integer-multiplier en/rdy protocol.
- It accepts {base, exp} requests from upstream and computes base^exp mod 2^p_nbits by square-and-multiply.
- Each square or multiply is issued as one request to an external multiplier: 2*p_nbits-bit req_msg {a,b}, p_nbits-bit resp_msg.
- The final result is returned upstream over a second en/rdy response port.

Parameters:
p_nbits, 32, operand/result width; exponent width also p_nbits

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req_en  in  1  upstream request fires this cycle (asserted only when req_rdy=1)
req_rdy  out  1  block can accept a request
req_msg  in  2*p_nbits  [2p-1:p]=base, [p-1:0]=exp
resp_en  out  1  result transfer fires this cycle
resp_rdy  in  1  upstream can accept result
resp_msg  out  p_nbits  base^exp mod 2^p_nbits
mul_req_en  out  1  multiplier request fires this cycle
mul_req_rdy  in  1  multiplier can accept request
mul_req_msg  out  2*p_nbits  {a, b} operands, a in upper half
mul_resp_en  in  1  multiplier response fires this cycle
mul_resp_rdy  out  1  block can accept multiplier response
mul_resp_msg  in  p_nbits  a*b truncated

Behaviour:
- Protocol rule: en means transfer. An en output is driven combinationally as (state condition && rdy), so en never asserts without rdy.
- Internal registers: acc, b, e (all p_nbits); FSM state.
- Reset (reset=0, async): state=IDLE, acc=1, b=0, e=0. Outputs: req_rdy=1, resp_en=0, mul_req_en=0, mul_resp_rdy=0, resp_msg=acc=1, mul_req_msg=0.
- IDLE: req_rdy=1.
  - On req_en: acc<=1, b<=base, e<=exp; go CHECK.
- CHECK: no handshakes.
  - e==0: go DONE.
  - e[0]==1: go MUL_REQ.
  - Otherwise: go SQ_REQ.
- MUL_REQ: mul_req_msg={acc,b}; mul_req_en=mul_req_rdy.
  - On fire: go MUL_WAIT. Otherwise hold (operands stable).
- MUL_WAIT: mul_resp_rdy=1.
  - On mul_resp_en: acc<=mul_resp_msg. If e[p-1:1]==0, e<=0 and go DONE; else go SQ_REQ.
- SQ_REQ: mul_req_msg={b,b}; mul_req_en=mul_req_rdy.
  - On fire: go SQ_WAIT.
- SQ_WAIT: mul_resp_rdy=1.
  - On mul_resp_en: b<=mul_resp_msg, e<=e>>1; go CHECK.
- DONE: resp_msg=acc; resp_en=resp_rdy.
  - On fire: go IDLE. Otherwise hold acc stable indefinitely.
- mul_req_msg is 0 outside the REQ states; resp_msg=acc in all states.
- req_rdy=0 in every state except IDLE. Exactly one request is in flight to the multiplier at any time.
- Arithmetic: all products truncated to p_nbits (mod 2^p_nbits); there is no overflow flag.
- Cost: number of multiplier transactions = popcount(exp) + floor(log2(exp)) for exp>0; 0 for exp=0.
- Latency, with a multiplier that responds the cycle after issue and all rdys high:
  - exp=0: accept at cycle t, resp_en at t+2.
  - Each multiply or square adds 2 cycles, plus 1 CHECK cycle per square.
- Back-pressure: mul_req_rdy low stalls in the REQ state; resp_rdy low stalls in DONE. No state is lost in either stall.
- mul_resp_en outside the WAIT states cannot occur, since mul_resp_rdy=0 there. The bench asserts this.
- Reset mid-operation: immediate return to IDLE; the in-flight multiplier operation is abandoned. The multiplier must share this reset so no stale response arrives later.
- Back-to-back: a new req is accepted only in the cycle after the DONE fire (IDLE). There is no request/response overlap.

Test Plan:
- base=3, exp=5, all rdys high -> exactly 4 mul transactions {3,3}? no: {1,3},{3,3},{9,9},{3,81} -> resp_msg=243, req_rdy returns 1 the cycle after the resp fire.
- base=0, exp=0 and base=7, exp=0 -> resp_msg=1 both times, zero mul transactions, resp_en at t+2.
- base=2, exp=32 -> resp_msg=0 (wrap); base=0xFFFFFFFF, exp=2 -> resp_msg=1; base=0xFFFFFFFF, exp=3 -> 0xFFFFFFFF.
- Random mul_req_rdy and resp_rdy back-pressure (50%) over 200 random {base,exp} -> all results match the mod-2^32 reference model; mul_req_msg stays stable while stalled.
- resp_rdy held 0 for 10 cycles in DONE for base=5, exp=3 -> resp_msg stays 125, req_rdy stays 0, single fire when released.
- Assert reset=0 during SQ_WAIT of base=3, exp=6 -> outputs return to reset values asynchronously; a next request base=2, exp=10 yields 1024.
